// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver, LSB first. Two-flop input synchronizer,
//                start-bit validation at mid-bit, centre sampling of data and
//                stop bits. Emits a one-cycle valid pulse per good byte and a
//                one-cycle framing-error pulse when the stop bit is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int c_CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int c_HALF_BIT     = (c_CLKS_PER_BIT - 1) / 2;
    localparam int c_CNT_W        = $clog2(c_CLKS_PER_BIT);

    // Counter compare values, pre-sized to the counter width.
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(c_HALF_BIT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } t_state;

    t_state             r_state;
    logic               r_sync1;
    logic               r_rx_s;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;

    // Two-flop synchronizer; resets to the idle (high) line level so no
    // false start bit is seen coming out of reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_rx_s  <= r_sync1;
        end
    end

    // Receive FSM: all decisions use the synchronized line; outputs are
    // registered and the two pulses default low every cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            o_data      <= 8'h00;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= 3'd0;
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        o_busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (r_cnt == c_CNT_HALF) begin
                        r_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state <= S_DATA;
                        end else begin
                            // Line went back high before mid-bit: a glitch.
                            r_state <= S_IDLE;
                            o_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                S_DATA: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                S_STOP: begin
                    if (r_cnt == c_CNT_LAST) begin
                        // Return to idle at mid-stop-bit so a start bit that
                        // follows immediately is still caught.
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                        if (r_rx_s) begin
                            o_data  <= r_shift;
                            o_valid <= 1'b1;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
